soc_top: RTL and testbench
==========================

# soc_top

Minimal single-cycle RV32I-subset system-on-chip: a 32-bit integer core plus a memory controller holding separate instruction and data RAMs. It is the top level of the core project and has no I/O beyond clock and reset. Benches observe it through hierarchical references and preload both RAMs with word-format hex images.

## Interface
- `IMEM_WORDS`, default 1024: instruction RAM depth in 32-bit words (power of two).
- `DMEM_WORDS`, default 1024: data RAM depth in 32-bit words (power of two).
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.

## Operation
- One instruction executes per clock: fetch, decode, execute, memory access and write-back are combinational within the cycle, and state commits at the rising edge.
- Fetch:
  - Instruction word is `instr_ram.mem[PC[log2(IMEM_WORDS)+1:2]]`.
  - Upper PC bits are ignored, so the index wraps.
  - PC[1:0] is always 0.
- Next PC is PC+4, modulo 2^32. There are no branches or jumps.
- Supported instructions (standard RV32I encodings):
  - LUI.
  - OP-IMM: ADDI, XORI, ORI, ANDI, using the sign-extended 12-bit immediate.
  - OP: ADD, SUB (funct7 = 0x20), XOR, OR, AND.
  - LOAD: LB, LH, LW, LBU, LHU.
  - STORE: SB, SH, SW.
- Any other opcode or funct combination executes as a NOP: no register write, no store, and PC+4.
- Register file:
  - 32 registers of 32 bits.
  - x0 reads as 0 and writes to it are discarded.
  - Two combinational read ports, one write port at the rising edge.
- Effective address is rs1 + sext(imm12), wrapping at 32 bits. Data word index is `addr[log2(DMEM_WORDS)+1:2]` and wraps.
- Loads:
  - Byte lane is selected by addr[1:0] for byte loads and by addr[1] for halfword loads.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Misalignment is ignored: LW ignores addr[1:0], and halfword loads ignore addr[0].
- Stores:
  - SB writes one byte lane and SH writes one halfword lane.
  - Other bytes of the word are preserved.
- Memory is little-endian.

## Timing
- Reset:
  - On a rising edge with rst=1: PC ← RESET_PC and all registers ← 0.
  - Memories are not affected, so preloaded images survive reset.
  - Reset asserted mid-program aborts the current instruction: no register write and no store in that cycle.
- After rst deasserts, the first instruction at RESET_PC commits on the first rising edge with rst=0.
- Register write-back and data RAM writes take effect at the rising edge that ends the instruction's cycle.
- Results are visible to the next instruction with no hazards, load-use included.
- A store followed by a load from the same address in the next instruction returns the stored data.
- Both RAMs use asynchronous (combinational) reads and synchronous writes. The instruction RAM is never written by the core.

## Structure
- Package `soc_pkg` holds:
  - opcode constants: OP_LUI 0x37, OP_IMM 0x13, OP 0x33, OP_LOAD 0x03, OP_STORE 0x23;
  - funct3 constants for the supported loads, stores and ALU operations;
  - the ALU operation enum.
- Required hierarchy, which benches reference by path:
  - `soc_top` instantiates `mem_controller` as `mem_controller_inst`.
  - `mem_controller_inst` contains RAM instances `instr_ram` and `data_ram`.
  - Each RAM stores its contents in a 32-bit array named `mem`.
- One RAM sub-module (`ram32`, parameterised by depth, with byte-enable write) serves both RAM instances.
- The core datapath lives in `core` (instance `core_inst`), with its register array named `rf`.

## Test plan
- Reset: hold rst=1 for 2 cycles → PC=0 and rf[1..31]=0. Then preload data_ram.mem[0]=0x800000F0 and release reset.
- Immediate and register ALU: program 0x00500093 (ADDI x1,x0,5), 0x00002103 (LW x2,0(x0)), 0x002082B3 (ADD x5,x1,x2) → after 3 cycles x1=5, x2=0x800000F0, x5=0x800000F5.
- Load extension: 0x00000183 (LB x3,0(x0)) and 0x00004203 (LBU x4,0(x0)) with mem[0]=0x800000F0 → x3=0xFFFFFFF0, x4=0x000000F0. LH at address 2 → 0xFFFF8000.
- Stores: 0x00202223 (SW x2,4(x0)) → data_ram.mem[1]=0x800000F0 one edge later. Then SB of x1=5 at address 5 → mem[1]=0x800005F0. Then LW from address 4 in the next instruction → 0x800005F0.
- x0 and NOP: ADDI x0,x0,7 → x0 reads 0. Word 0xFFFFFFFF → no state change and PC advances by 4.
- Reset mid-run: assert rst during an SW → no store occurs and PC=RESET_PC at the next edge.

Source files
------------

// File: rtl/soc_pkg.sv
// Shared encodings for the RV32I-subset core: opcodes, funct fields and ALU operations.
package soc_pkg;

  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP       = 7'h33;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;

  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_XOR = 3'd4;
  localparam logic [2:0] F3_OR  = 3'd6;
  localparam logic [2:0] F3_AND = 3'd7;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_SUB  = 7'h20;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_XOR,
    ALU_OR,
    ALU_AND,
    ALU_PASS_B
  } alu_op_e;

  function automatic logic [31:0] alu_exec(input alu_op_e op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] res;
    case (op)
      ALU_SUB:    res = a - b;
      ALU_XOR:    res = a ^ b;
      ALU_OR:     res = a | b;
      ALU_AND:    res = a & b;
      ALU_PASS_B: res = b;
      default:    res = a + b;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/core.sv
// Single-cycle RV32I-subset datapath: PC, register file, decode, ALU and load/store lane logic.
module core
  import soc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] o_pc,
  input  logic [31:0] i_instr,
  output logic [31:0] o_daddr,
  output logic        o_dwe,
  output logic [3:0]  o_dbe,
  output logic [31:0] o_dwdata,
  input  logic [31:0] i_drdata
);

  logic [31:0] r_pc;
  logic [31:0] rf [32];

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_u;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;

  assign w_opcode = i_instr[6:0];
  assign w_rd     = i_instr[11:7];
  assign w_funct3 = i_instr[14:12];
  assign w_rs1    = i_instr[19:15];
  assign w_rs2    = i_instr[24:20];
  assign w_funct7 = i_instr[31:25];
  assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_u  = {i_instr[31:12], 12'd0};

  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : rf[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : rf[w_rs2];

  logic        w_rd_we;
  logic        w_is_load;
  logic        w_is_store;
  alu_op_e     w_alu_op;
  logic [31:0] w_op_b;

  // Anything not matched below leaves every enable low, which is the NOP behaviour.
  always_comb begin
    w_rd_we    = 1'b0;
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_alu_op   = ALU_ADD;
    w_op_b     = w_imm_i;
    case (w_opcode)
      OP_LUI: begin
        w_rd_we  = 1'b1;
        w_alu_op = ALU_PASS_B;
        w_op_b   = w_imm_u;
      end
      OP_IMM: begin
        case (w_funct3)
          F3_ADD:  begin w_rd_we = 1'b1; w_alu_op = ALU_ADD; end
          F3_XOR:  begin w_rd_we = 1'b1; w_alu_op = ALU_XOR; end
          F3_OR:   begin w_rd_we = 1'b1; w_alu_op = ALU_OR;  end
          F3_AND:  begin w_rd_we = 1'b1; w_alu_op = ALU_AND; end
          default: ;
        endcase
      end
      OP: begin
        w_op_b = w_rs2_val;
        if (w_funct7 == F7_BASE) begin
          case (w_funct3)
            F3_ADD:  begin w_rd_we = 1'b1; w_alu_op = ALU_ADD; end
            F3_XOR:  begin w_rd_we = 1'b1; w_alu_op = ALU_XOR; end
            F3_OR:   begin w_rd_we = 1'b1; w_alu_op = ALU_OR;  end
            F3_AND:  begin w_rd_we = 1'b1; w_alu_op = ALU_AND; end
            default: ;
          endcase
        end else if (w_funct7 == F7_SUB && w_funct3 == F3_ADD) begin
          w_rd_we  = 1'b1;
          w_alu_op = ALU_SUB;
        end
      end
      OP_LOAD: begin
        case (w_funct3)
          F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: begin
            w_rd_we   = 1'b1;
            w_is_load = 1'b1;
          end
          default: ;
        endcase
      end
      OP_STORE: begin
        w_op_b = w_imm_s;
        case (w_funct3)
          F3_SB, F3_SH, F3_SW: w_is_store = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  logic [31:0] w_alu_res;
  assign w_alu_res = alu_exec(w_alu_op, w_rs1_val, w_op_b);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_wb_data;

  assign w_shifted = i_drdata >> {w_alu_res[1:0], 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = w_alu_res[1] ? i_drdata[31:16] : i_drdata[15:0];

  always_comb begin
    w_load_data = i_drdata;
    case (w_funct3)
      F3_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  w_load_data = {24'd0, w_byte};
      F3_LH:   w_load_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  w_load_data = {16'd0, w_half};
      default: ;
    endcase
  end

  assign w_wb_data = w_is_load ? w_load_data : w_alu_res;

  // Narrow stores replicate the source across all lanes and let the byte enables pick one.
  always_comb begin
    o_dwdata = w_rs2_val;
    o_dbe    = 4'b1111;
    case (w_funct3)
      F3_SB: begin
        o_dwdata = {4{w_rs2_val[7:0]}};
        o_dbe    = 4'b0001 << w_alu_res[1:0];
      end
      F3_SH: begin
        o_dwdata = {2{w_rs2_val[15:0]}};
        o_dbe    = w_alu_res[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign o_pc    = r_pc;
  assign o_daddr = w_alu_res;
  assign o_dwe   = w_is_store & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      r_pc <= r_pc + 32'd4;
      if (w_rd_we && (w_rd != 5'd0)) rf[w_rd] <= w_wb_data;
    end
  end

endmodule

// File: rtl/mem_controller.sv
// Holds the instruction and data RAMs; both are indexed by word and wrap on their depth.
module mem_controller #(
  parameter int IMEM_WORDS = 1024,
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic [31:0] i_pc,
  output logic [31:0] o_instr,
  input  logic [31:0] i_daddr,
  input  logic        i_dwe,
  input  logic [3:0]  i_dbe,
  input  logic [31:0] i_dwdata,
  output logic [31:0] o_drdata
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  // Upper address bits are deliberately dropped so accesses wrap; byte offsets live in the core.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{i_pc[31:IAW+2], i_pc[1:0], i_daddr[31:DAW+2], i_daddr[1:0]};

  ram32 #(.WORDS(IMEM_WORDS)) instr_ram (
    .clk    (clk),
    .i_we   (1'b0),
    .i_be   (4'b0000),
    .i_addr (i_pc[IAW+1:2]),
    .i_wdata(32'd0),
    .o_rdata(o_instr)
  );

  ram32 #(.WORDS(DMEM_WORDS)) data_ram (
    .clk    (clk),
    .i_we   (i_dwe),
    .i_be   (i_dbe),
    .i_addr (i_daddr[DAW+1:2]),
    .i_wdata(i_dwdata),
    .o_rdata(o_drdata)
  );

endmodule

// File: rtl/ram32.sv
// 32-bit wide RAM with combinational read and byte-enable synchronous write.
module ram32 #(
  parameter int WORDS = 1024
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [3:0]               i_be,
  input  logic [$clog2(WORDS)-1:0] i_addr,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);

  logic [31:0] mem [WORDS];

  assign o_rdata = mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/soc_top.sv
// Minimal RV32I-subset system: one single-cycle core wired to the instruction/data memory controller.
module soc_top
  import soc_pkg::*;
#(
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);

  logic [31:0] w_pc;
  logic [31:0] w_instr;
  logic [31:0] w_daddr;
  logic        w_dwe;
  logic [3:0]  w_dbe;
  logic [31:0] w_dwdata;
  logic [31:0] w_drdata;

  core #(.RESET_PC(RESET_PC)) core_inst (
    .clk     (clk),
    .rst     (rst),
    .o_pc    (w_pc),
    .i_instr (w_instr),
    .o_daddr (w_daddr),
    .o_dwe   (w_dwe),
    .o_dbe   (w_dbe),
    .o_dwdata(w_dwdata),
    .i_drdata(w_drdata)
  );

  mem_controller #(
    .IMEM_WORDS(IMEM_WORDS),
    .DMEM_WORDS(DMEM_WORDS)
  ) mem_controller_inst (
    .clk     (clk),
    .i_pc    (w_pc),
    .o_instr (w_instr),
    .i_daddr (w_daddr),
    .i_dwe   (w_dwe),
    .i_dbe   (w_dbe),
    .i_dwdata(w_dwdata),
    .o_drdata(w_drdata)
  );

endmodule

// File: tb/tb_soc_top.sv
// Runs a directed program on soc_top against an instruction-level model with a byte-addressed data memory.
module tb_soc_top;

  localparam int IW = 1024;
  localparam int DW = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  soc_top #(.IMEM_WORDS(IW), .DMEM_WORDS(DW), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .rst(rst)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] m_pc;
  logic [31:0] m_rf    [32];
  logic [7:0]  m_bytes [DW*4];
  logic [31:0] m_prog  [IW];
  bit          m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return m_bytes[a[11:0]];
  endfunction

  function automatic logic [31:0] m_word(input int w);
    return {m_bytes[4*w+3], m_bytes[4*w+2], m_bytes[4*w+1], m_bytes[4*w]};
  endfunction

  // Architectural model: executes one instruction straight from the ISA rules.
  task automatic model_step(input logic reset);
    logic [31:0] ins, a, b, immi, imms, res, addr;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    bit          wr;
    if (reset) begin
      m_pc = 32'h0000_0000;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_valid = 1'b1;
      $display("[TB] reset edge, pc <= %08h", m_pc);
      return;
    end
    ins  = m_prog[m_pc[11:2]];
    op   = ins[6:0];
    rd   = ins[11:7];
    f3   = ins[14:12];
    f7   = ins[31:25];
    a    = m_rf[ins[19:15]];
    b    = m_rf[ins[24:20]];
    immi = {{20{ins[31]}}, ins[31:20]};
    imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    res  = 32'd0;
    wr   = 1'b0;
    if (op == 7'h37) begin
      res = ins & 32'hFFFF_F000; wr = 1'b1;
    end else if (op == 7'h13) begin
      wr = 1'b1;
      if (f3 == 3'd0) res = a + immi;
      else if (f3 == 3'd4) res = a ^ immi;
      else if (f3 == 3'd6) res = a | immi;
      else if (f3 == 3'd7) res = a & immi;
      else wr = 1'b0;
    end else if (op == 7'h33) begin
      wr = 1'b1;
      if (f7 == 7'h00 && f3 == 3'd0) res = a + b;
      else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
      else if (f7 == 7'h00 && f3 == 3'd4) res = a ^ b;
      else if (f7 == 7'h00 && f3 == 3'd6) res = a | b;
      else if (f7 == 7'h00 && f3 == 3'd7) res = a & b;
      else wr = 1'b0;
    end else if (op == 7'h03) begin
      addr = a + immi;
      wr   = 1'b1;
      if (f3 == 3'd0) res = 32'($signed(rd_byte(addr)));
      else if (f3 == 3'd4) res = {24'd0, rd_byte(addr)};
      else if (f3 == 3'd1) res = 32'($signed({rd_byte((addr & ~32'd1) + 1), rd_byte(addr & ~32'd1)}));
      else if (f3 == 3'd5) res = {16'd0, rd_byte((addr & ~32'd1) + 1), rd_byte(addr & ~32'd1)};
      else if (f3 == 3'd2) res = {rd_byte((addr & ~32'd3) + 3), rd_byte((addr & ~32'd3) + 2),
                                  rd_byte((addr & ~32'd3) + 1), rd_byte(addr & ~32'd3)};
      else wr = 1'b0;
    end else if (op == 7'h23) begin
      addr = a + imms;
      if (f3 == 3'd0) begin
        m_bytes[addr[11:0]] = b[7:0];
      end else if (f3 == 3'd1) begin
        for (int k = 0; k < 2; k++) begin
          logic [31:0] ba;
          ba = (addr & ~32'd1) + k;
          m_bytes[ba[11:0]] = b[8*k +: 8];
        end
      end else if (f3 == 3'd2) begin
        for (int k = 0; k < 4; k++) begin
          logic [31:0] ba;
          ba = (addr & ~32'd3) + k;
          m_bytes[ba[11:0]] = b[8*k +: 8];
        end
      end
    end
    if (wr && rd != 5'd0) m_rf[rd] = res;
    $display("[TB] pc=%08h instr=%08h", m_pc, ins);
    m_pc = m_pc + 32'd4;
  endtask

  // Compare process: DUT architectural state against the model on every falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("pc", dut.core_inst.r_pc, m_pc);
      for (int i = 0; i < 32; i++) check($sformatf("rf[%0d]", i), dut.core_inst.rf[i], m_rf[i]);
      for (int w = 0; w < 4; w++)
        check($sformatf("dmem[%0d]", w), dut.mem_controller_inst.data_ram.mem[w], m_word(w));
    end
  end

  task automatic cycle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_step(rst);
      @(negedge clk);
      #2;
    end
  endtask

  initial begin
    for (int i = 0; i < IW; i++) m_prog[i] = 32'h0000_0000;
    m_prog[0]  = 32'h00500093; // ADDI x1,x0,5
    m_prog[1]  = 32'h00002103; // LW   x2,0(x0)
    m_prog[2]  = 32'h002082B3; // ADD  x5,x1,x2
    m_prog[3]  = 32'h00000183; // LB   x3,0(x0)
    m_prog[4]  = 32'h00004203; // LBU  x4,0(x0)
    m_prog[5]  = 32'h00201303; // LH   x6,2(x0)
    m_prog[6]  = 32'h00202223; // SW   x2,4(x0)
    m_prog[7]  = 32'h001002A3; // SB   x1,5(x0)
    m_prog[8]  = 32'h00402383; // LW   x7,4(x0)
    m_prog[9]  = 32'h00700013; // ADDI x0,x0,7
    m_prog[10] = 32'hFFFFFFFF; // illegal -> NOP
    m_prog[11] = 32'h40208433; // SUB  x8,x1,x2
    m_prog[12] = 32'hFFF14493; // XORI x9,x2,-1
    m_prog[13] = 32'h12345537; // LUI  x10,0x12345
    m_prog[14] = 32'h0F056593; // ORI  x11,x10,0x0F0
    m_prog[15] = 32'h0025F633; // AND  x12,x11,x2
    m_prog[16] = 32'h00B01323; // SH   x11,6(x0)
    m_prog[17] = 32'h00605683; // LHU  x13,6(x0)
    m_prog[18] = 32'h00202423; // SW   x2,8(x0)  (aborted by reset)
    for (int i = 0; i < IW; i++) dut.mem_controller_inst.instr_ram.mem[i] = m_prog[i];
    for (int i = 0; i < DW; i++) dut.mem_controller_inst.data_ram.mem[i] = 32'd0;
    for (int i = 0; i < DW*4; i++) m_bytes[i] = 8'd0;

    rst = 1'b1;
    cycle(2);
    check("reset pc", dut.core_inst.r_pc, 32'h0);
    for (int i = 1; i < 32; i++) check($sformatf("reset rf[%0d]", i), dut.core_inst.rf[i], 32'h0);

    dut.mem_controller_inst.data_ram.mem[0] = 32'h800000F0;
    m_bytes[0] = 8'hF0; m_bytes[1] = 8'h00; m_bytes[2] = 8'h00; m_bytes[3] = 8'h80;
    rst = 1'b0;

    cycle(3);
    check("addi x1", dut.core_inst.rf[1], 32'h00000005);
    check("lw x2",   dut.core_inst.rf[2], 32'h800000F0);
    check("add x5",  dut.core_inst.rf[5], 32'h800000F5);
    cycle(3);
    check("lb x3",   dut.core_inst.rf[3], 32'hFFFFFFF0);
    check("lbu x4",  dut.core_inst.rf[4], 32'h000000F0);
    check("lh x6",   dut.core_inst.rf[6], 32'hFFFF8000);
    cycle(1);
    check("sw mem1", dut.mem_controller_inst.data_ram.mem[1], 32'h800000F0);
    cycle(1);
    check("sb mem1", dut.mem_controller_inst.data_ram.mem[1], 32'h800005F0);
    cycle(1);
    check("lw x7 after sb", dut.core_inst.rf[7], 32'h800005F0);
    cycle(1);
    check("x0 kept 0", dut.core_inst.rf[0], 32'h0);
    check("pc after x0 write", dut.core_inst.r_pc, 32'h00000028);
    cycle(1);
    check("nop pc", dut.core_inst.r_pc, 32'h0000002C);
    check("nop x7 kept", dut.core_inst.rf[7], 32'h800005F0);
    cycle(7);
    check("sub x8",  dut.core_inst.rf[8],  32'h7FFFFF15);
    check("xori x9", dut.core_inst.rf[9],  32'h7FFFFF0F);
    check("lui x10", dut.core_inst.rf[10], 32'h12345000);
    check("ori x11", dut.core_inst.rf[11], 32'h123450F0);
    check("and x12", dut.core_inst.rf[12], 32'h000000F0);
    check("sh mem1", dut.mem_controller_inst.data_ram.mem[1], 32'h50F005F0);
    check("lhu x13", dut.core_inst.rf[13], 32'h000050F0);
    check("pc at sw", dut.core_inst.r_pc, 32'h00000048);

    rst = 1'b1;
    cycle(1);
    check("abort pc", dut.core_inst.r_pc, 32'h0);
    check("abort no store", dut.mem_controller_inst.data_ram.mem[2], 32'h0);
    check("abort x2 cleared", dut.core_inst.rf[2], 32'h0);
    rst = 1'b0;
    cycle(1);
    check("restart x1", dut.core_inst.rf[1], 32'h00000005);
    check("restart pc", dut.core_inst.r_pc, 32'h00000004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
